instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
- Consumer side of the program counter: owns the fetch PC, issues sequential requests to instruction memory, and buffers returned words.
- Presents the buffered words with their PCs to decode over a valid/ready handshake.
- Sits between the PC/branch-resolution logic (redirect input) and the decode stage.
- Supports up to DEPTH outstanding-or-buffered instructions and discards stale responses after a redirect.

Parameters:
- RESET_PC, 32'h00000000, fetch PC loaded on reset.
- DEPTH, 2, prefetch buffer entries and maximum in-flight plus buffered fetches (power of 2, ≥1).

Ports:
- clk  in  1  clock; all state on posedge.
- rst  in  1  synchronous active-high reset.
- redirect_en  in  1  load new fetch PC and flush (taken branch/jump).
- redirect_pc  in  32  target PC for redirect_en.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  fetch address (current fetch PC).
- imem_gnt  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  response valid; responses are in order, at least 1 cycle after gnt.
- imem_rdata  in  32  instruction word, valid with imem_rvalid.
- if_valid  out  1  buffered instruction available to decode.
- if_ready  in  1  decode accepts the instruction this cycle.
- if_instr  out  32  instruction at the buffer head.
- if_pc  out  32  PC of if_instr.

Behaviour:
- Reset: fetch_pc=RESET_PC; buffer empty; outstanding=0; drop=0; imem_req=0, if_valid=0, if_instr=0, if_pc=0. Reset overrides all other inputs, including mid-transaction.
- Credits: imem_req=1 when (outstanding + occupancy) < DEPTH and !redirect_en; imem_addr=fetch_pc.
- Request hold: while imem_req=1 and imem_gnt=0, addr stays stable and req stays high (except a redirect, which may withdraw it).
- Grant: on imem_req & imem_gnt, fetch_pc += 4 (mod 2^32, 32'hFFFFFFFC wraps to 0); outstanding += 1; the granted PC is pushed into a PC-tag queue of depth DEPTH.
- Response with drop=0: the word plus the head PC tag is written into the buffer; outstanding -= 1. Available as if_valid the cycle after rvalid (1-cycle latency, no combinational bypass).
- Response with drop>0: the word is discarded, drop -= 1, outstanding -= 1, and the PC tag is popped.
- Dequeue: if_valid & if_ready pops the head; the next entry appears the following cycle. Push and pop in the same cycle are both honoured.
- Redirect (redirect_en=1):
  - Next cycle: fetch_pc=redirect_pc and the buffer is empty (if_valid=0).
  - drop = outstanding - (rvalid this cycle ? 1 : 0) + (gnt this cycle ? 1 : 0). imem_req is forced 0 in the redirect cycle, so gnt is normally 0.
  - if_ready in the redirect cycle is ignored.
- Redirect while drop>0: accumulate per the same formula; never reload drop to a smaller value.
- Full: when occupancy + outstanding == DEPTH, imem_req=0 until a dequeue.
- Unexpected imem_rvalid with outstanding=0: ignored, no state change.
- Counter widths: $clog2(DEPTH)+1 bits.

Optional Feature:
- Macro: FETCH_MISALIGN_CHECK_EN.
- Defined:
  - Adds output misalign_fault (1 bit, reset 0).
  - A redirect_pc with bits [1:0] != 0 sets misalign_fault=1 the next cycle, holds imem_req=0, and keeps fetch_pc at the faulting value.
  - The fault clears on rst or on a later redirect with an aligned target.
- Undefined: no port; bits [1:0] of redirect_pc are forced to 0 when loaded.

Test Plan:
1. Reset then run with gnt=1 and rvalid 1 cycle later, if_ready=1 -> imem_addr 0,4,8,...; if_pc 0,4,8 with matching instr; if_valid first high 2 cycles after the first gnt.
2. if_ready=0 with DEPTH=2 -> exactly 2 grants (addr 0,4), then imem_req=0. Set if_ready=1 -> instr@0 dequeued, req resumes at addr 8.
3. Hold imem_gnt=0 for 3 cycles -> imem_req=1 and imem_addr=0 stable all 3 cycles; pc advances only after gnt.
4. Two requests in flight, then redirect_en with redirect_pc=0x100 -> both late responses dropped; the next if_pc=0x100; if_valid=0 the cycle after the redirect.
5. Push and pop in the same cycle with the buffer at 1 entry -> occupancy stays 1 and order is preserved. rst asserted mid-flight -> all outputs return to reset values next cycle; the first addr after reset = RESET_PC.
6. With FETCH_MISALIGN_CHECK_EN: redirect_pc=0x102 -> misalign_fault=1, imem_req=0. Redirect to 0x200 -> fault clears and fetch resumes at 0x200.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Fetch PC owner: in-order imem requests, DEPTH-entry prefetch buffer, 1-cycle response-to-decode latency.
// Optional macro FETCH_MISALIGN_CHECK_EN adds misalign_fault; otherwise redirect targets are word-aligned.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic        misalign_fault
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0]   r_fetch_pc;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_drop;
  logic [CW-1:0] r_count;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_tag_rd;
  logic [PW-1:0] r_tag_wr;
  logic [31:0]   r_buf_instr [DEPTH];
  logic [31:0]   r_buf_pc    [DEPTH];
  logic [31:0]   r_tag       [DEPTH];

  logic          w_gnt;
  logic          w_resp;
  logic          w_keep;
  logic          w_pop;
  logic          w_fault;
  logic [CW:0]   w_used;
  logic [31:0]   w_target;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic r_fault;
  assign w_fault        = r_fault;
  assign misalign_fault = r_fault;
  assign w_target       = redirect_pc;
`else
  assign w_fault  = 1'b0;
  assign w_target = redirect_pc & 32'hFFFF_FFFC;
`endif

  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    w_used    = {1'b0, r_outstanding} + {1'b0, r_count};
    imem_req  = !rst && !redirect_en && !w_fault && (w_used < (CW+1)'(DEPTH));
    imem_addr = r_fetch_pc;
    w_gnt     = imem_req && imem_gnt;
    // Responses with nothing outstanding are spurious and must not disturb any state.
    w_resp    = imem_rvalid && (r_outstanding != '0);
    w_keep    = w_resp && (r_drop == '0);
    if_valid  = (r_count != '0);
    w_pop     = if_valid && if_ready && !redirect_en;
    if_instr  = if_valid ? r_buf_instr[r_rd_ptr] : 32'h0;
    if_pc     = if_valid ? r_buf_pc[r_rd_ptr]    : 32'h0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_outstanding <= '0;
      r_drop        <= '0;
      r_count       <= '0;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_tag_rd      <= '0;
      r_tag_wr      <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
      r_fault       <= 1'b0;
`endif
    end else begin
      r_outstanding <= r_outstanding + CW'(w_gnt) - CW'(w_resp);
      if (w_gnt) begin
        r_tag[r_tag_wr] <= r_fetch_pc;
        r_tag_wr        <= f_inc(r_tag_wr);
      end
      if (w_resp) r_tag_rd <= f_inc(r_tag_rd);
      if (redirect_en) begin
        r_fetch_pc <= w_target;
        // Every response still in flight belongs to the old path.
        r_drop     <= r_outstanding - CW'(w_resp) + CW'(w_gnt);
        r_count    <= '0;
        r_rd_ptr   <= '0;
        r_wr_ptr   <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
        r_fault    <= (redirect_pc[1:0] != 2'b00);
`endif
      end else begin
        if (w_gnt) r_fetch_pc <= r_fetch_pc + 32'd4;
        if (w_resp && (r_drop != '0)) r_drop <= r_drop - CW'(1);
        if (w_keep) begin
          r_buf_instr[r_wr_ptr] <= imem_rdata;
          r_buf_pc[r_wr_ptr]    <= r_tag[r_tag_rd];
          r_wr_ptr              <= f_inc(r_wr_ptr);
        end
        if (w_pop) r_rd_ptr <= f_inc(r_rd_ptr);
        r_count <= r_count + CW'(w_keep) - CW'(w_pop);
      end
    end
  end

endmodule
